// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial packed-BCD adder/subtractor controller: one shared single-digit BCD add stage,
// one digit per clock, LSD first, with valid/ready handshakes on both sides.
module bcd_serial_adder_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  op_sub,
    input  logic                  cin,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Nine's complement of every digit; invalid digits simply wrap modulo 16.
    function automatic logic [W-1:0] nines_vec(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'd9 - v[4*i +: 4];
        end
        return r;
    endfunction

    function automatic logic any_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad = bad | (v[4*i +: 4] > 4'd9);
        end
        return bad;
    endfunction

    // Returns {carry_out, digit}.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] da, input logic [3:0] db,
                                                 input logic c);
        logic [4:0] s;
        logic [4:0] adj;
        s   = {1'b0, da} + {1'b0, db} + {4'd0, c};
        adj = s + 5'd6;
        return (s > 5'd9) ? {1'b1, adj[3:0]} : {1'b0, s[3:0]};
    endfunction

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            err_q, err_d;

    logic [IW+1:0]   sh_s;
    logic [W-1:0]    a_sh_s;
    logic [W-1:0]    b_sh_s;
    logic [4:0]      dsum_s;

    // Current-digit operand selection and the shared BCD add stage.
    always_comb begin
        sh_s   = {idx_q, 2'b00};
        a_sh_s = a_q >> sh_s;
        b_sh_s = b_q >> sh_s;
        dsum_s = bcd_digit_add(a_sh_s[3:0], b_sh_s[3:0], carry_q);
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = op_sub ? nines_vec(b) : b;
                    carry_d = op_sub ? 1'b1 : cin;
                    err_d   = any_bad_digit(a) | any_bad_digit(b);
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d   = (sum_q & ~(W'(4'hF) << sh_s)) | (W'(dsum_s[3:0]) << sh_s);
                carry_d = dsum_s[4];
                if (idx_q == IW'(DIGITS - 1)) begin
                    cout_d  = dsum_s[4];
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign err       = err_q;

endmodule
